// File: rtl/syn_rx_param.sv
// rtl/syn_rx_param.sv - parametrised 1-wire sync-word receiver
// Start/data/parity/stop deserialiser with glitch rejection, frame checks and error counting.
module syn_rx_param #(
  parameter int DATA_W     = 8,
  parameter int BIT_CLKS   = 5,
  parameter int START_LEN  = 3,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clk_10M,
  input  logic              rst,
  input  logic              data_to_slave,
  output logic              syn_set,
  output logic [DATA_W-1:0] syn_time,
  output logic              load_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int H  = BIT_CLKS / 2;
  localparam int CW = $clog2(BIT_CLKS);
  localparam int BW = $clog2(DATA_W + 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, REARM} state_t;

  state_t            state, state_n;
  logic              sync1, line;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DATA_W-1:0] shadow, shadow_n, shift_val, lo_bit, hi_bit;
  logic [DATA_W-1:0] time_n;
  logic              par, par_n, par_bad, par_bad_n;
  logic              set_n, load_n, ferr_n, perr_n;
  logic [7:0]        err_n;
  logic              mid;

  always_ff @(posedge clk_10M or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      line  <= 1'b0;
    end else begin
      sync1 <= data_to_slave;
      line  <= sync1;
    end
  end

  assign cnt_inc = (cnt == CW'(BIT_CLKS - 1)) ? '0 : cnt + CW'(1);
  assign mid     = (cnt == CW'(H));

  always_comb begin
    lo_bit    = '0;
    lo_bit[0] = line;
    hi_bit    = '0;
    hi_bit[DATA_W-1] = line;
    shift_val = (MSB_FIRST != 0) ? ((shadow << 1) | lo_bit) : ((shadow >> 1) | hi_bit);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    shadow_n  = shadow;
    par_n     = par;
    par_bad_n = par_bad;
    time_n    = syn_time;
    err_n     = err_cnt;
    set_n     = 1'b0;
    load_n    = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (line) begin
          // cnt tracks cycles since the first high sample, modulo one bit period
          cnt_n     = CW'(1);
          bit_n     = '0;
          par_n     = 1'b0;
          par_bad_n = 1'b0;
          if (START_LEN == 1) begin
            set_n   = 1'b1;
            state_n = DATA;
          end else begin
            state_n = START;
          end
        end
      end
      START: begin
        if (!line) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (cnt == CW'(START_LEN - 1)) begin
            set_n   = 1'b1;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        cnt_n = cnt_inc;
        if (cnt == CW'(BIT_CLKS - 1))
          bit_n = bit_cnt + BW'(1);
        // bit period 0 is the start bit, so its midpoint is skipped
        if (mid && bit_cnt != '0) begin
          shadow_n = shift_val;
          par_n    = par ^ line;
          if (bit_cnt == BW'(DATA_W))
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        cnt_n = cnt_inc;
        if (mid) begin
          par_bad_n = ((par ^ line) != 1'(PARITY_ODD));
          state_n   = STOP;
        end
      end
      STOP: begin
        cnt_n = cnt_inc;
        if (mid) begin
          if (line || par_bad) begin
            ferr_n = line;
            perr_n = par_bad;
            err_n  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
          end else begin
            time_n = shadow;
            load_n = 1'b1;
          end
          state_n = REARM;
        end
      end
      REARM: begin
        if (!line)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_10M or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shadow     <= '0;
      par        <= 1'b0;
      par_bad    <= 1'b0;
      syn_time   <= '0;
      err_cnt    <= 8'd0;
      syn_set    <= 1'b0;
      load_ready <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      shadow     <= shadow_n;
      par        <= par_n;
      par_bad    <= par_bad_n;
      syn_time   <= time_n;
      err_cnt    <= err_n;
      syn_set    <= set_n;
      load_ready <= load_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
